// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU run sequencer.
//   seq_state_e    : sequencer FSM states
//   DEF_DATA_W     : default operand/result width
//   DEF_RST_CYCLES : default number of cycles the CPU is held in reset per run
//   DEF_TIMEOUT    : default number of RUN cycles allowed before giving up
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/cpu_seq_timer.sv
// Loadable up-counter shared by the LOAD hold and the RUN timeout.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   restart  : set the count to 1 on the next edge (first cycle of a phase)
//   en       : advance the count by one
//   limit    : value at which the current phase ends
//   cnt      : current count (1-based cycle number within the phase)
//   done     : cnt equals limit
module cpu_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = CNT_W'(1);
    end else if (en && (cnt_q != '1)) begin
      // Saturate rather than wrap so a stuck phase can never look fresh.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == limit);

endmodule

// File: rtl/cpu_run_sequencer.sv
// Drives one operand pair into an attached CPU, holds the CPU in reset for
// RST_CYCLES, releases it, waits for cpu_Halt (or TIMEOUT RUN cycles) and
// presents the captured result on a valid/ready output.
// Ports:
//   Clock, Reset                  : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b   : operand handshake (accepted only in IDLE)
//   cpu_A, cpu_B                  : operands held toward the CPU
//   cpu_Reset                     : CPU reset, low only while the CPU runs
//   cpu_Halt, cpu_Output          : CPU completion flag and result
//   res_valid/res_ready           : result handshake
//   res_data, res_timeout         : captured result, timeout indication
//   busy                          : sequencer not idle
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] cpu_A,
  output logic [DATA_W-1:0] cpu_B,
  output logic              cpu_Reset,
  input  logic              cpu_Halt,
  input  logic [DATA_W-1:0] cpu_Output,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_timeout,
  output logic              busy
);

  // One counter serves both phases, so it must reach the larger limit.
  localparam int CNT_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] cpu_a_q, cpu_a_d;
  logic [DATA_W-1:0] cpu_b_q, cpu_b_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_timeout_q, res_timeout_d;

  logic              tmr_restart;
  logic              tmr_en;
  logic [CNT_W-1:0]  tmr_limit;
  logic [CNT_W-1:0]  tmr_cnt;
  logic              tmr_done;

  cpu_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (Clock),
    .rst     (Reset),
    .restart (tmr_restart),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .cnt     (tmr_cnt),
    .done    (tmr_done)
  );

  always_comb begin
    state_d       = state_q;
    cpu_a_d       = cpu_a_q;
    cpu_b_d       = cpu_b_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    tmr_restart   = 1'b0;
    tmr_en        = 1'b0;
    tmr_limit     = CNT_W'(TIMEOUT);

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          cpu_a_d     = in_a;
          cpu_b_d     = in_b;
          tmr_restart = 1'b1;
          state_d     = ST_LOAD;
        end
      end

      ST_LOAD: begin
        tmr_limit = CNT_W'(RST_CYCLES);
        if (tmr_done) begin
          tmr_restart = 1'b1;
          state_d     = ST_RUN;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_RUN: begin
        // Halt on the first RUN cycle is left over from the previous run.
        if (cpu_Halt && (tmr_cnt >= CNT_W'(2))) begin
          res_data_d    = cpu_Output;
          res_timeout_d = 1'b0;
          state_d       = ST_DONE;
        end else if (tmr_done) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      cpu_a_q       <= '0;
      cpu_b_q       <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_a_q       <= cpu_a_d;
      cpu_b_q       <= cpu_b_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Gated by Reset so nothing is accepted while reset is still asserted.
  assign in_ready    = (state_q == ST_IDLE) && !Reset;
  assign cpu_A       = cpu_a_q;
  assign cpu_B       = cpu_b_q;
  assign cpu_Reset   = (state_q != ST_RUN);
  assign res_valid   = (state_q == ST_DONE);
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer: directed scenarios followed by
// randomized runs, checked against an outcome model computed from the
// run rules (reset hold length, first accepted halt cycle, timeout).
module tb_cpu_run_sequencer;

  localparam int DATA_W     = 8;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 16;

  logic              Clock       = 1'b0;
  logic              Reset       = 1'b1;
  logic              in_valid    = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_a        = '0;
  logic [DATA_W-1:0] in_b        = '0;
  logic [DATA_W-1:0] cpu_A;
  logic [DATA_W-1:0] cpu_B;
  logic              cpu_Reset;
  logic              cpu_Halt    = 1'b0;
  logic [DATA_W-1:0] cpu_Output  = '0;
  logic              res_valid;
  logic              res_ready   = 1'b0;
  logic [DATA_W-1:0] res_data;
  logic              res_timeout;
  logic              busy;

  int tests = 0;
  int fails = 0;

  // CPU behaviour knobs, set by the stimulus before each run.
  int                cpu_halt_at = 1000;
  bit                cpu_stale   = 1'b0;
  logic [DATA_W-1:0] cpu_out     = '0;
  int                run_cyc     = 0;

  cpu_run_sequencer #(
    .DATA_W     (DATA_W),
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .cpu_A       (cpu_A),
    .cpu_B       (cpu_B),
    .cpu_Reset   (cpu_Reset),
    .cpu_Halt    (cpu_Halt),
    .cpu_Output  (cpu_Output),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  always #5 Clock = ~Clock;

  // CPU model: counts cycles since its reset was released and raises Halt
  // from cycle cpu_halt_at onward; optionally a stale Halt on cycle 1.
  always @(negedge Clock) begin
    int rc;
    rc = cpu_Reset ? 0 : run_cyc + 1;
    run_cyc <= rc;
    if (rc == 0) begin
      cpu_Halt   <= 1'b0;
      cpu_Output <= DATA_W'($urandom);
    end else if (rc >= cpu_halt_at) begin
      cpu_Halt   <= 1'b1;
      cpu_Output <= cpu_out;
    end else if (rc == 1 && cpu_stale) begin
      cpu_Halt   <= 1'b1;
      cpu_Output <= DATA_W'($urandom);
    end else begin
      cpu_Halt   <= 1'b0;
      cpu_Output <= DATA_W'($urandom);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Offer one operand pair and complete the handshake; leaves time at
  // 1 unit after the accepting edge.
  task automatic start(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input int h_at, input bit stale, input logic [DATA_W-1:0] out);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_push", 32'(in_ready), 32'd1);
    cpu_halt_at = h_at;
    cpu_stale   = stale;
    cpu_out     = out;
    in_valid    = 1'b1;
    in_a        = a;
    in_b        = b;
    tick();
    in_valid    = 1'b0;
    in_a        = DATA_W'($urandom);
    in_b        = DATA_W'($urandom);
    chk("cpu_A_latched", 32'(cpu_A), 32'(a));
    chk("cpu_B_latched", 32'(cpu_B), 32'(b));
    chk("busy_after_push", 32'(busy), 32'd1);
    chk("in_ready_after_push", 32'(in_ready), 32'd0);
  endtask

  // Full transaction with outcome model: the run ends on the first cycle
  // in 2..TIMEOUT where Halt is high, otherwise at cycle TIMEOUT.
  task automatic run_txn(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input int h_at, input bit stale, input logic [DATA_W-1:0] out,
                         input int hold);
    int                n;
    int                exp_len;
    bit                exp_to;
    logic [DATA_W-1:0] exp_data;
    exp_to   = (h_at > TIMEOUT);
    exp_len  = exp_to ? TIMEOUT : ((h_at < 2) ? 2 : h_at);
    exp_data = exp_to ? '0 : out;

    start(a, b, h_at, stale, out);

    n = 0;
    while (cpu_Reset && n < 50) begin
      n++;
      tick();
    end
    chk("load_len", 32'(n), 32'(RST_CYCLES));

    n = 0;
    while (!res_valid && n < 100) begin
      n++;
      tick();
    end
    chk("run_len", 32'(n), 32'(exp_len));
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_data", 32'(res_data), 32'(exp_data));
    chk("res_timeout", 32'(res_timeout), 32'(exp_to));
    chk("cpu_A_held", 32'(cpu_A), 32'(a));

    if (hold > 0) begin
      in_valid = 1'b1;
      in_a     = 8'd7;
      in_b     = 8'd1;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res_data", 32'(res_data), 32'(exp_data));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_cleared", 32'(res_valid), 32'd0);
    chk("in_ready_after_done", 32'(in_ready), 32'd1);
    chk("cpu_A_not_reaccepted", 32'(cpu_A), 32'(a));
  endtask

  initial begin
    bit seen;

    // Reset held for three cycles
    Reset = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cpu_Reset", 32'(cpu_Reset), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cpu_A", 32'(cpu_A), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_timeout", 32'(res_timeout), 32'd0);
    Reset = 1'b0;
    tick();
    chk("in_ready_after_release", 32'(in_ready), 32'd1);

    // Basic run: halt with 9 on RUN cycle 5
    run_txn(8'd5, 8'd4, 5, 1'b0, 8'd9, 0);
    // Halt never raised: timeout
    run_txn(8'h11, 8'h22, 1000, 1'b0, 8'h55, 0);
    // Consumer stalls 10 cycles while a new pair is offered
    run_txn(8'h21, 8'h13, 7, 1'b0, 8'h34, 10);
    // Stale Halt on cycle 1 ignored
    run_txn(8'h0A, 8'h0B, 12, 1'b1, 8'h66, 1);
    // Stale Halt alone does not end the run
    run_txn(8'h0C, 8'h0D, 1000, 1'b1, 8'h44, 0);
    // Halt exactly on the timeout cycle wins
    run_txn(8'h0E, 8'h0F, TIMEOUT, 1'b1, 8'h77, 0);
    // Halt high from cycle 1 is accepted on cycle 2
    run_txn(8'h1E, 8'h2F, 1, 1'b0, 8'h88, 2);

    // Reset in the middle of RUN aborts the run
    start(8'hC3, 8'h5A, 1000, 1'b0, 8'h99);
    repeat (RST_CYCLES + 3) tick();
    chk("mid_run_cpu_Reset_low", 32'(cpu_Reset), 32'd0);
    Reset = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cpu_Reset", 32'(cpu_Reset), 32'd1);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_cpu_A", 32'(cpu_A), 32'd0);
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_txn(8'd3, 8'd2, 4, 1'b0, 8'd5, 0);

    // Randomized runs
    for (int t = 0; t < 20; t++) begin
      run_txn(DATA_W'($urandom), DATA_W'($urandom), int'($urandom_range(1, 20)),
              bit'($urandom_range(0, 1)), DATA_W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
